seq_pattern_tx: RTL and testbench

Serial pattern transmitter: accepts a parallel bit pattern, its length and a repeat count over a valid/ready handshake, then drives the pattern MSB-first onto a one-bit serial line, one bit per clock. It is the stimulus/driver end of the serial bit-stream interface that the sequence-detector blocks consume. It sits upstream of a detector's `x` input, in benches and in lab top-levels.

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_piso.sv | 41 ++++
 rtl/seq_pattern_tx.sv | 196 +++++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared state codes and default sizes
// for the serial pattern transmitter family.
package seq_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'b00;
   localparam state_t ST_SHIFT = 2'b01;
   localparam state_t ST_GAP   = 2'b10;
   localparam state_t ST_DONE  = 2'b11;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_LEN_W   = 4;
   localparam int DEF_REP_W   = 4;

endpackage

// File: rtl/seq_piso.sv
// seq_piso: parallel-in serial-out register.
// Pattern is left-aligned on load so the current bit is always the MSB.
module seq_piso
   import seq_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = DEF_LEN_W
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               load,
   input  logic               shift,
   input  logic [MAX_LEN-1:0] data,
   input  logic [LEN_W-1:0]   len,
   output logic               q
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] sreg;
   logic [LEN_W-1:0]   pad;

   // Bit len-1 of the pattern lands in the top position.
   always_comb begin
      pad = MAX_LEN_L - len;
   end

   // Load takes priority; shifting moves the next bit into the MSB.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= data << pad;
      end else if (shift) begin
         sreg <= sreg << 1;
      end
   end

   assign q = sreg[MAX_LEN-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: sends a latched pattern MSB-first on x,
// repeated pat_rep+1 times with optional idle gaps between copies.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int   MAX_LEN  = DEF_MAX_LEN,
   parameter int   LEN_W    = DEF_LEN_W,
   parameter int   REP_W    = DEF_REP_W,
   parameter int   GAP      = 0,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [MAX_LEN-1:0] pat_data,
   input  logic [LEN_W-1:0]   pat_len,
   input  logic [REP_W-1:0]   pat_rep,
   input  logic               pat_valid,
   output logic               pat_ready,
   output logic               x,
   output logic               x_valid,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [3:0] GAP_M1 =
      (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_t state;
   state_t nstate;

   logic [MAX_LEN-1:0] data_q;
   logic [LEN_W-1:0]   len_q;
   logic [REP_W-1:0]   rep_q;
   logic [LEN_W-1:0]   idx_q;
   logic [3:0]         gap_q;
   logic               err_q;

   logic               accept;
   logic               len_bad;
   logic               last_bit;
   logic               rep_more;
   logic               piso_load;
   logic               piso_shift;
   logic [MAX_LEN-1:0] piso_data;
   logic [LEN_W-1:0]   piso_len;
   logic               piso_q;

   // Handshake and counter status decode.
   always_comb begin
      accept   = pat_valid && (state == ST_IDLE);
      len_bad  = (pat_len == '0) || (pat_len > MAX_LEN_L);
      last_bit = (idx_q == '0);
      rep_more = (rep_q != '0);
   end

   // Shift register control: fresh load at accept, reload per repeat.
   always_comb begin
      piso_load  = 1'b0;
      piso_shift = 1'b0;
      piso_data  = data_q;
      piso_len   = len_q;
      if (state == ST_IDLE) begin
         piso_data = pat_data;
         piso_len  = pat_len;
         piso_load = accept && !len_bad;
      end else if (state == ST_SHIFT) begin
         piso_shift = !last_bit;
         piso_load  = last_bit && rep_more;
      end
   end

   seq_piso #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_piso (
      .clk   (clk),
      .rstn  (rstn),
      .load  (piso_load),
      .shift (piso_shift),
      .data  (piso_data),
      .len   (piso_len),
      .q     (piso_q)
   );

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= nstate;
      end
   end

   // Next-state logic.
   always_comb begin
      nstate = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               nstate = len_bad ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last_bit) begin
               if (!rep_more) begin
                  nstate = ST_DONE;
               end else if (GAP > 0) begin
                  nstate = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == '0) begin
               nstate = ST_SHIFT;
            end
         end
         ST_DONE: begin
            nstate = ST_IDLE;
         end
         default: begin
            nstate = ST_IDLE;
         end
      endcase
   end

   // Request latch plus bit, repeat and gap counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= '0;
         len_q  <= '0;
         rep_q  <= '0;
         idx_q  <= '0;
         gap_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  data_q <= pat_data;
                  len_q  <= pat_len;
                  rep_q  <= pat_rep;
                  idx_q  <= pat_len - 1'b1;
                  err_q  <= len_bad;
               end
            end
            ST_SHIFT: begin
               if (!last_bit) begin
                  idx_q <= idx_q - 1'b1;
               end else if (rep_more) begin
                  rep_q <= rep_q - 1'b1;
                  idx_q <= len_q - 1'b1;
                  gap_q <= GAP_M1;
               end
            end
            ST_GAP: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: begin
               gap_q <= gap_q;
            end
         endcase
      end
   end

   // Moore outputs decoded from registered state and data.
   always_comb begin
      pat_ready = 1'b0;
      busy      = 1'b1;
      x         = IDLE_BIT;
      x_valid   = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            pat_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_SHIFT: begin
            x       = piso_q;
            x_valid = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
            err  = err_q;
         end
         default: begin
            x = IDLE_BIT;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed vectors against two builds
// (GAP=0 and GAP=2) sharing clock, reset and pattern inputs.
module tb_seq_pattern_tx;
   import seq_pkg::*;

   logic       clk;
   logic       rstn;
   logic [7:0] pat_data;
   logic [3:0] pat_len;
   logic [3:0] pat_rep;
   logic       pv0, pv2;
   logic       rdy0, x0, xv0, busy0, done0, err0;
   logic       rdy2, x2, xv2, busy2, done2, err2;

   int n_chk;
   int n_err;

   seq_pattern_tx #(.GAP(0), .IDLE_BIT(1'b0)) dut0 (
      .clk       (clk),
      .rstn      (rstn),
      .pat_data  (pat_data),
      .pat_len   (pat_len),
      .pat_rep   (pat_rep),
      .pat_valid (pv0),
      .pat_ready (rdy0),
      .x         (x0),
      .x_valid   (xv0),
      .busy      (busy0),
      .done      (done0),
      .err       (err0)
   );

   seq_pattern_tx #(.GAP(2), .IDLE_BIT(1'b0)) dut2 (
      .clk       (clk),
      .rstn      (rstn),
      .pat_data  (pat_data),
      .pat_len   (pat_len),
      .pat_rep   (pat_rep),
      .pat_valid (pv2),
      .pat_ready (rdy2),
      .x         (x2),
      .x_valid   (xv2),
      .busy      (busy2),
      .done      (done2),
      .err       (err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pat_ready, busy, x_valid, x, done, err}
   function automatic logic [5:0] obs(int sel);
      if (sel == 0) return {rdy0, busy0, xv0, x0, done0, err0};
      return {rdy2, busy2, xv2, x2, done2, err2};
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", tag, got[5:0], exp[5:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int sel, input logic [7:0] d,
                       input logic [3:0] l, input logic [3:0] r);
      pat_data = d;
      pat_len  = l;
      pat_rep  = r;
      if (sel == 0) pv0 = 1'b1; else pv2 = 1'b1;
      tick();
      pv0 = 1'b0;
      pv2 = 1'b0;
   endtask

   // Checks n stream cycles (MSB first), the done cycle and the idle cycle.
   task automatic run_stream(input string name, input int sel,
                             input int n, input logic [15:0] xs,
                             input logic [15:0] vs, input logic e);
      for (int i = n - 1; i >= 0; i--) begin
         chk($sformatf("%s bit%0d", name, n - 1 - i), 32'(obs(sel)),
             32'({1'b0, 1'b1, vs[i], xs[i], 2'b00}));
         tick();
      end
      chk({name, " done"}, 32'(obs(sel)),
          32'({4'b0100, 1'b1, e}));
      tick();
      chk({name, " ready"}, 32'(obs(sel)), 32'(6'b100000));
   endtask

   initial begin
      n_chk    = 0;
      n_err    = 0;
      rstn     = 1'b0;
      pv0      = 1'b0;
      pv2      = 1'b0;
      pat_data = '0;
      pat_len  = '0;
      pat_rep  = '0;
      tick();
      chk("reset0", 32'(obs(0)), 32'(6'b100000));
      chk("reset2", 32'(obs(2)), 32'(6'b100000));
      tick();
      rstn = 1'b1;
      tick();

      send(0, 8'b0000_0101, 4'd3, 4'd0);
      run_stream("single", 0, 3, 16'b101, 16'b111, 1'b0);

      send(0, 8'b0000_0110, 4'd3, 4'd2);
      run_stream("b2b", 0, 9, 16'b110110110, 16'b111111111, 1'b0);

      send(2, 8'b0000_0101, 4'd3, 4'd1);
      run_stream("gap", 2, 8, 16'b10100101, 16'b11100111, 1'b0);

      send(0, 8'hA5, 4'd0, 4'd0);
      run_stream("len0", 0, 0, 16'd0, 16'd0, 1'b1);

      send(0, 8'hA5, 4'd9, 4'd0);
      run_stream("len9", 0, 0, 16'd0, 16'd0, 1'b1);

      // Request A accepted, then B held on the inputs throughout.
      pat_data = 8'b0000_1011;
      pat_len  = 4'd4;
      pat_rep  = 4'd0;
      pv0      = 1'b1;
      tick();
      pat_data = 8'b0000_0001;
      pat_len  = 4'd2;
      pat_rep  = 4'd0;
      for (int i = 3; i >= 0; i--) begin
         logic [3:0] a;
         a = 4'b1011;
         chk($sformatf("held A bit%0d", 3 - i), 32'(obs(0)),
             32'({3'b011, a[i], 2'b00}));
         tick();
      end
      chk("held A done", 32'(obs(0)), 32'(6'b010010));
      tick();
      chk("held idle", 32'(obs(0)), 32'(6'b100000));
      tick();
      pv0 = 1'b0;
      run_stream("held B", 0, 2, 16'b01, 16'b11, 1'b0);

      // Abort mid-SHIFT with an asynchronous reset.
      send(0, 8'hFF, 4'd8, 4'd0);
      chk("abort bit0", 32'(obs(0)), 32'(6'b011100));
      tick();
      chk("abort bit1", 32'(obs(0)), 32'(6'b011100));
      tick();
      #2;
      rstn = 1'b0;
      #1;
      chk("abort async", 32'(obs(0)), 32'(6'b100000));
      tick();
      chk("abort held", 32'(obs(0)), 32'(6'b100000));
      rstn = 1'b1;
      tick();
      chk("abort nodone", 32'(obs(0)), 32'(6'b100000));
      send(0, 8'b0000_0010, 4'd2, 4'd0);
      run_stream("post", 0, 2, 16'b10, 16'b11, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
